// File: rtl/rot_pkg.sv
// Shared widths, lane count and FSM encoding for the rotation offset sequencer.
package rot_pkg;

    localparam int unsigned BW_XCOS = 10;
    localparam int unsigned BW_OFF  = 6;
    localparam int unsigned N_LANE  = 128;
    localparam int unsigned FRAC    = BW_XCOS - 5;
    localparam int unsigned N_SLICE = 4;

    localparam logic [1:0] LAST_SLICE = 2'(N_SLICE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CALC  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/rot_round_sat.sv
// One lane: signed add or subtract of two fixed-point coefficients, round half-up
// to an integer and saturate into the offset width.
module rot_round_sat
    import rot_pkg::*;
(
    input  logic [BW_XCOS-1:0] a,
    input  logic [BW_XCOS-1:0] b,
    input  logic               sub,
    output logic [BW_OFF-1:0]  off_c
);

    // One bit beyond the sum width so the rounding bias can never wrap.
    localparam int unsigned SW = BW_XCOS + 2;

    localparam logic signed [SW-1:0] HALF    = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] MAX_OFF = SW'((1 << (BW_OFF - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_OFF = SW'(-(1 << (BW_OFF - 1)));

    logic signed [SW-1:0] a_ext;
    logic signed [SW-1:0] b_ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rnd;

    always_comb begin
        a_ext = SW'(signed'(a));
        b_ext = SW'(signed'(b));
        sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        rnd   = (sum + HALF) >>> FRAC;
        if (rnd > MAX_OFF) begin
            off_c = BW_OFF'(MAX_OFF);
        end else if (rnd < MIN_OFF) begin
            off_c = BW_OFF'(MIN_OFF);
        end else begin
            off_c = BW_OFF'(rnd);
        end
    end

endmodule

// File: rtl/rotation_offset_sequencer.sv
// Walks the rotation mux through its four slices and presents the rounded,
// rotated sample offsets of each slice over a valid/ready handshake.
module rotation_offset_sequencer
    import rot_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic [1:0]                cnt,
    output logic                      cnt_ena,
    input  logic [N_LANE*BW_XCOS-1:0] cosx_vec,
    input  logic [N_LANE*BW_XCOS-1:0] sinx_vec,
    input  logic [N_LANE*BW_XCOS-1:0] cosy_vec,
    input  logic [N_LANE*BW_XCOS-1:0] siny_vec,
    output logic [N_LANE*BW_OFF-1:0]  off_x,
    output logic [N_LANE*BW_OFF-1:0]  off_y,
    output logic [1:0]                off_idx,
    output logic                      off_valid,
    input  logic                      off_ready,
    output logic                      done
);

    state_t                    state;
    logic [1:0]                slice;
    logic [N_LANE*BW_OFF-1:0]  off_x_c;
    logic [N_LANE*BW_OFF-1:0]  off_y_c;

    // x' = cosx - siny, y' = sinx + cosy for every lane.
    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        rot_round_sat u_x (
            .a     (cosx_vec[i*BW_XCOS +: BW_XCOS]),
            .b     (siny_vec[i*BW_XCOS +: BW_XCOS]),
            .sub   (1'b1),
            .off_c (off_x_c[i*BW_OFF +: BW_OFF])
        );
        rot_round_sat u_y (
            .a     (sinx_vec[i*BW_XCOS +: BW_XCOS]),
            .b     (cosy_vec[i*BW_XCOS +: BW_XCOS]),
            .sub   (1'b0),
            .off_c (off_y_c[i*BW_OFF +: BW_OFF])
        );
    end

    // Sequencer FSM with registered mux controls and offset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slice     <= 2'd0;
            busy      <= 1'b0;
            cnt       <= 2'd0;
            cnt_ena   <= 1'b0;
            off_x     <= '0;
            off_y     <= '0;
            off_idx   <= 2'd0;
            off_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        slice   <= 2'd0;
                        cnt     <= 2'd0;
                        cnt_ena <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_ena <= 1'b0;
                    state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    off_x     <= off_x_c;
                    off_y     <= off_y_c;
                    off_idx   <= slice;
                    off_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (off_ready) begin
                        off_valid <= 1'b0;
                        if (slice != LAST_SLICE) begin
                            slice   <= slice + 2'd1;
                            cnt     <= slice + 2'd1;
                            cnt_ena <= 1'b1;
                            state   <= ST_ISSUE;
                        end else begin
                            slice <= 2'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotation_offset_sequencer.sv
// Scoreboard bench: a mux model feeds per-slice vectors, expected slices are queued
// at start and popped by a monitor on each accepted handshake.
module tb_rotation_offset_sequencer;
    import rot_pkg::*;

    localparam int unsigned XW = N_LANE * BW_XCOS;
    localparam int unsigned OW = N_LANE * BW_OFF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic [1:0]    cnt;
    logic          cnt_ena;
    logic [XW-1:0] cosx_vec;
    logic [XW-1:0] sinx_vec;
    logic [XW-1:0] cosy_vec;
    logic [XW-1:0] siny_vec;
    logic [OW-1:0] off_x;
    logic [OW-1:0] off_y;
    logic [1:0]    off_idx;
    logic          off_valid;
    logic          off_ready;
    logic          done;

    typedef struct packed {
        logic [1:0]    idx;
        logic [OW-1:0] x;
        logic [OW-1:0] y;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          exp_e[N_SLICE];
    exp_t          mon_e;
    int            cx[N_SLICE][N_LANE];
    int            sx[N_SLICE][N_LANE];
    int            cy[N_SLICE][N_LANE];
    int            sy[N_SLICE][N_LANE];
    logic [XW-1:0] cx_v[N_SLICE];
    logic [XW-1:0] sx_v[N_SLICE];
    logic [XW-1:0] cy_v[N_SLICE];
    logic [XW-1:0] sy_v[N_SLICE];
    logic [OW-1:0] acc_x[N_SLICE];
    logic [OW-1:0] acc_y[N_SLICE];
    int            n_tests = 0;
    int            n_fail  = 0;

    rotation_offset_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .cnt       (cnt),
        .cnt_ena   (cnt_ena),
        .cosx_vec  (cosx_vec),
        .sinx_vec  (sinx_vec),
        .cosy_vec  (cosy_vec),
        .siny_vec  (siny_vec),
        .off_x     (off_x),
        .off_y     (off_y),
        .off_idx   (off_idx),
        .off_valid (off_valid),
        .off_ready (off_ready),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream mux: registers the selected slice on a cnt_ena edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cosx_vec <= '0;
            sinx_vec <= '0;
            cosy_vec <= '0;
            siny_vec <= '0;
        end else if (cnt_ena) begin
            cosx_vec <= cx_v[cnt];
            sinx_vec <= sx_v[cnt];
            cosy_vec <= cy_v[cnt];
            siny_vec <= sy_v[cnt];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        int bad;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            bad = -1;
            for (int i = 0; i < int'(N_LANE); i++) begin
                if (bad < 0 && got[i*BW_OFF +: BW_OFF] !== exp[i*BW_OFF +: BW_OFF]) bad = i;
            end
            $display("FAIL %s: lane %0d got %0h expected %0h", name, bad,
                     got[bad*BW_OFF +: BW_OFF], exp[bad*BW_OFF +: BW_OFF]);
        end
    endtask

    // Integer reference: floor((s + 0.5*32) / 32), clamped to the 6-bit signed range.
    function automatic int ref_lane(input int a, input int b, input bit sub);
        int s;
        int t;
        int r;
        s = sub ? (a - b) : (a + b);
        t = s + 16;
        if (t >= 0) r = t / 32;
        else        r = -((-t + 31) / 32);
        if (r > 31)  r = 31;
        if (r < -32) r = -32;
        return r;
    endfunction

    // Control outputs {busy,cnt_ena,cnt,off_valid,done}, c cycles after the start edge, ready high.
    function automatic logic [5:0] exp_word(input int c);
        logic       b;
        logic       e;
        logic [1:0] k;
        logic       v;
        logic       d;
        b = (c < 16);
        e = (c % 4 == 0) && (c < 16);
        k = (c < 12) ? 2'(c / 4) : 2'd3;
        v = (c % 4 == 3) && (c < 16);
        d = (c == 16);
        return {b, e, k, v, d};
    endfunction

    function automatic logic [BW_OFF-1:0] lane_of(input logic [OW-1:0] v, input int i);
        return v[i*BW_OFF +: BW_OFF];
    endfunction

    task automatic build_data();
        logic [OW-1:0] ex;
        logic [OW-1:0] ey;
        for (int k = 0; k < int'(N_SLICE); k++) begin
            for (int i = 0; i < int'(N_LANE); i++) begin
                cx[k][i] = ((i * 37 + k * 101) % 1024) - 512;
                sy[k][i] = ((i * 53 + k * 29 + 7) % 1024) - 512;
                sx[k][i] = ((i * 71 + k * 13 + 300) % 1024) - 512;
                cy[k][i] = ((i * 19 + k * 211 + 600) % 1024) - 512;
            end
        end
        cx[0][0] = 112;  sy[0][0] = 32;   sx[0][0] = -24;  cy[0][0] = 0;
        cx[1][0] = -16;  sy[1][0] = 0;
        cx[1][1] = 16;   sy[1][1] = 0;
        cx[1][2] = -48;  sy[1][2] = 0;
        sx[1][3] = -16;  cy[1][3] = 0;
        sx[1][4] = 16;   cy[1][4] = 0;
        cx[2][0] = 511;  sy[2][0] = -512; sx[2][0] = 511;  cy[2][0] = 511;
        cx[2][1] = -512; sy[2][1] = 511;  sx[2][1] = -512; cy[2][1] = -512;
        for (int k = 0; k < int'(N_SLICE); k++) begin
            for (int i = 0; i < int'(N_LANE); i++) begin
                cx_v[k][i*BW_XCOS +: BW_XCOS] = BW_XCOS'(cx[k][i]);
                sx_v[k][i*BW_XCOS +: BW_XCOS] = BW_XCOS'(sx[k][i]);
                cy_v[k][i*BW_XCOS +: BW_XCOS] = BW_XCOS'(cy[k][i]);
                sy_v[k][i*BW_XCOS +: BW_XCOS] = BW_XCOS'(sy[k][i]);
                ex[i*BW_OFF +: BW_OFF] = BW_OFF'(ref_lane(cx[k][i], sy[k][i], 1'b1));
                ey[i*BW_OFF +: BW_OFF] = BW_OFF'(ref_lane(sx[k][i], cy[k][i], 1'b0));
            end
            exp_e[k].idx = 2'(k);
            exp_e[k].x   = ex;
            exp_e[k].y   = ey;
        end
    endtask

    task automatic push_all();
        for (int k = 0; k < int'(N_SLICE); k++) sb_q.push_back(exp_e[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input int c, input logic [5:0] exp);
        check($sformatf("%s_ctrl_c%0d", tag, c), 64'({busy, cnt_ena, cnt, off_valid, done}), 64'(exp));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, cnt_ena, cnt, off_valid, done}), 64'(0));
        check({tag, "_off_idx"}, 64'(off_idx), 64'(0));
        check_vec({tag, "_off_x"}, off_x, '0);
        check_vec({tag, "_off_y"}, off_y, '0);
    endtask

    // Monitor: every accepted slice is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && off_valid && off_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'(1), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_off_idx", 64'(off_idx), 64'(mon_e.idx));
                check_vec($sformatf("sb_off_x_s%0d", mon_e.idx), off_x, mon_e.x);
                check_vec($sformatf("sb_off_y_s%0d", mon_e.idx), off_y, mon_e.y);
                acc_x[off_idx] = off_x;
                acc_y[off_idx] = off_y;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        off_ready = 1'b1;
        build_data();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Free-running sequence; a start during the done pulse must be dropped.
        push_all();
        pulse_start();
        for (int c = 0; c <= 17; c++) begin
            check_ctrl("run", c, exp_word(c));
            if (c == 16) start = 1'b1;
            if (c == 17) start = 1'b0;
            tick();
        end
        check("run_sb_empty", 64'(sb_q.size()), 64'(0));

        check("hand_s0_l0_x", 64'(lane_of(acc_x[0], 0)), 64'(6'd3));
        check("hand_s0_l0_y", 64'(lane_of(acc_y[0], 0)), 64'(6'h3f));
        check("tie_neg_half_x", 64'(lane_of(acc_x[1], 0)), 64'(6'd0));
        check("tie_pos_half_x", 64'(lane_of(acc_x[1], 1)), 64'(6'd1));
        check("tie_neg_1p5_x", 64'(lane_of(acc_x[1], 2)), 64'(6'h3f));
        check("tie_neg_half_y", 64'(lane_of(acc_y[1], 3)), 64'(6'd0));
        check("tie_pos_half_y", 64'(lane_of(acc_y[1], 4)), 64'(6'd1));
        check("sat_pos_x", 64'(lane_of(acc_x[2], 0)), 64'(6'h1f));
        check("sat_neg_x", 64'(lane_of(acc_x[2], 1)), 64'(6'h20));
        check("sat_pos_y", 64'(lane_of(acc_y[2], 0)), 64'(6'h1f));
        check("sat_neg_y", 64'(lane_of(acc_y[2], 1)), 64'(6'h20));

        // Backpressure on slice 1, plus a start while busy.
        push_all();
        pulse_start();
        for (int c = 0; c <= 22; c++) begin
            if (c <= 6) begin
                check_ctrl("bp", c, exp_word(c));
            end else if (c <= 11) begin
                check_ctrl("bp_stall", c, {1'b1, 1'b0, 2'd1, 1'b1, 1'b0});
                check($sformatf("bp_stall_idx_c%0d", c), 64'(off_idx), 64'(1));
                check_vec($sformatf("bp_stall_x_c%0d", c), off_x, exp_e[1].x);
                check_vec($sformatf("bp_stall_y_c%0d", c), off_y, exp_e[1].y);
            end else begin
                check_ctrl("bp", c, exp_word(c - 4));
            end
            if (c == 6)  off_ready = 1'b0;
            if (c == 11) off_ready = 1'b1;
            if (c == 9)  start = 1'b1;
            if (c == 10) start = 1'b0;
            tick();
        end
        check("bp_sb_empty", 64'(sb_q.size()), 64'(0));

        // Reset while slice 2 is in CALC, then a clean restart.
        push_all();
        pulse_start();
        for (int c = 0; c <= 9; c++) begin
            check_ctrl("rst", c, exp_word(c));
            tick();
        end
        check_ctrl("rst", 10, exp_word(10));
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        check("mid_reset_sb_left", 64'(sb_q.size()), 64'(2));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_all();
        pulse_start();
        for (int c = 0; c <= 17; c++) begin
            check_ctrl("restart", c, exp_word(c));
            tick();
        end
        check("restart_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
